// File: rtl/decode_div_pkg.sv
// Shared types and default-configuration constants for the decoder's iterative signed divider.
// Holds the FSM state encoding plus counter width and quotient saturation limits.
package decode_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DIN0_W = 70;
  localparam int DIN1_W = 31;
  localparam int DOUT_W = 40;

  localparam int CNT_W = $clog2(DIN0_W + 1);

  localparam logic signed [DOUT_W-1:0] QMAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic signed [DOUT_W-1:0] QMIN = {1'b1, {(DOUT_W-1){1'b0}}};

endpackage

// File: rtl/decode_div_step.sv
// One combinational restoring-division step on magnitudes: shift in a dividend bit, trial-subtract.
// Zero latency; no flow control.
module decode_div_step #(
  parameter int W = 31
) (
  input  logic [W-1:0] prem,
  input  logic         dividend_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] next_prem,
  output logic         qbit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // prem < divisor <= 2^(W-1), so shifted never sets its top bit and W+1 bits cannot overflow.
  always_comb begin
    shifted   = {prem, dividend_msb};
    diff      = shifted - {1'b0, divisor};
    qbit      = ~diff[W];
    next_prem = qbit ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/decode_sdiv_70s_31s_40_seq.sv
// Signed restoring divider, 70s / 31s -> 40s quotient (saturated) + 31s remainder, start/done handshake.
// Latency din0_WIDTH+1 enabled edges from accept to done; start ignored while busy, ce=0 freezes all state.
module decode_sdiv_70s_31s_40_seq
  import decode_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  divzero
);

  localparam int unused_id = ID;

  localparam int                    CW   = $clog2(din0_WIDTH + 1);
  localparam logic [CW-1:0]         LAST = CW'(din0_WIDTH - 1);
  localparam logic [CW-1:0]         ONE  = CW'(1);

  // Largest quotient magnitudes that still fit the signed output, positive and negative side.
  localparam logic [din0_WIDTH-1:0] POS_LIM =
    {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic [din0_WIDTH-1:0] NEG_LIM =
    {{(din0_WIDTH-dout_WIDTH){1'b0}}, 1'b1, {(dout_WIDTH-1){1'b0}}};

  localparam logic [dout_WIDTH-1:0] QPOS = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] QNEG = {1'b1, {(dout_WIDTH-1){1'b0}}};

  state_t                  state_q,   state_d;
  logic [CW-1:0]           cnt_q,     cnt_d;
  logic [din0_WIDTH-1:0]   dvd_q,     dvd_d;
  logic [din1_WIDTH-1:0]   dsr_q,     dsr_d;
  logic [din1_WIDTH-1:0]   prem_q,    prem_d;
  logic                    s0_q,      s0_d;
  logic                    s1_q,      s1_d;
  logic                    busy_q,    busy_d;
  logic                    done_q,    done_d;
  logic [dout_WIDTH-1:0]   dout_q,    dout_d;
  logic [din1_WIDTH-1:0]   rem_q,     rem_d;
  logic                    ovf_q,     ovf_d;
  logic                    divzero_q, divzero_d;

  logic [din1_WIDTH-1:0]   step_prem;
  logic                    step_qbit;

  decode_div_step #(
    .W (din1_WIDTH)
  ) u_step (
    .prem         (prem_q),
    .dividend_msb (dvd_q[din0_WIDTH-1]),
    .divisor      (dsr_q),
    .next_prem    (step_prem),
    .qbit         (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    prem_d    = prem_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    busy_d    = busy_q;
    done_d    = done_q;
    dout_d    = dout_q;
    rem_d     = rem_q;
    ovf_d     = ovf_q;
    divzero_d = divzero_q;

    if (ce) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CALC;
            // Unsigned reading of the negated value is exact even for the most negative input.
            dvd_d   = din0[din0_WIDTH-1] ? -din0 : din0;
            dsr_d   = din1[din1_WIDTH-1] ? -din1 : din1;
            s0_d    = din0[din0_WIDTH-1];
            s1_d    = din1[din1_WIDTH-1];
            prem_d  = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end

        CALC: begin
          // Quotient bits enter at the bottom as dividend bits leave the top.
          prem_d = step_prem;
          dvd_d  = {dvd_q[din0_WIDTH-2:0], step_qbit};
          cnt_d  = cnt_q + ONE;
          if (cnt_q == LAST) begin
            state_d = FIX;
          end
        end

        FIX: begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          divzero_d = (dsr_q == '0);
          // With a zero divisor every step keeps the shifted value, so prem ends as |din0| low bits.
          rem_d     = s0_q ? -prem_q : prem_q;
          if (dsr_q == '0) begin
            dout_d = s0_q ? QNEG : QPOS;
            ovf_d  = 1'b1;
          end else if (s0_q ^ s1_q) begin
            if (dvd_q > NEG_LIM) begin
              dout_d = QNEG;
              ovf_d  = 1'b1;
            end else begin
              dout_d = -dvd_q[dout_WIDTH-1:0];
              ovf_d  = 1'b0;
            end
          end else begin
            if (dvd_q > POS_LIM) begin
              dout_d = QPOS;
              ovf_d  = 1'b1;
            end else begin
              dout_d = dvd_q[dout_WIDTH-1:0];
              ovf_d  = 1'b0;
            end
          end
        end

        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      prem_q    <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= '0;
      rem_q     <= '0;
      ovf_q     <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      prem_q    <= prem_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dout_q    <= dout_d;
      rem_q     <= rem_d;
      ovf_q     <= ovf_d;
      divzero_q <= divzero_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dout    = dout_q;
  assign rem     = rem_q;
  assign ovf     = ovf_q;
  assign divzero = divzero_q;

endmodule

// File: tb/tb_decode_sdiv_70s_31s_40_seq.sv
// Directed bench for the 70s/31s signed divider: latency, signs, saturation, divide-by-zero, handshake.
module tb_decode_sdiv_70s_31s_40_seq;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic               start;
  logic signed [69:0] din0;
  logic signed [30:0] din1;
  logic               busy;
  logic               done;
  logic signed [39:0] dout;
  logic signed [30:0] rem;
  logic               ovf;
  logic               divzero;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic signed [39:0] QMAX = 40'sh7F_FFFF_FFFF;
  localparam logic signed [39:0] QMIN = 40'sh80_0000_0000;

  decode_sdiv_70s_31s_40_seq dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .start   (start),
    .din0    (din0),
    .din1    (din1),
    .busy    (busy),
    .done    (done),
    .dout    (dout),
    .rem     (rem),
    .ovf     (ovf),
    .divzero (divzero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [69:0] obs, input logic signed [69:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic signed [69:0] a, input logic signed [30:0] b);
    @(negedge clk);
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done; optionally drops ce for 10 edges after edge pause_at.
  task automatic wait_done(input int pause_at, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (n == pause_at) ce = 1'b0;
      if (pause_at > 0 && n == pause_at + 10) ce = 1'b1;
      if (done) break;
    end
  endtask

  task automatic run(input string tag, input logic signed [69:0] a, input logic signed [30:0] b,
                     input logic signed [39:0] eq, input logic signed [30:0] er,
                     input logic eo, input logic ez);
    int n;
    do_start(a, b);
    wait_done(-1, n);
    chk({tag, ".latency"}, n, 71);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".dout"}, dout, eq);
    chk({tag, ".rem"}, rem, er);
    chk({tag, ".ovf"}, ovf, eo);
    chk({tag, ".divzero"}, divzero, ez);
  endtask

  initial begin
    int                 n;
    int                 seen;
    logic signed [69:0] big;
    logic [63:0]        r;
    logic signed [39:0] a;
    logic signed [30:0] b;
    logic signed [69:0] p;

    reset = 1'b1;
    ce    = 1'b0;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.dout", dout, 0);
    chk("reset.rem", rem, 0);
    chk("reset.ovf", ovf, 0);
    chk("reset.divzero", divzero, 0);
    reset = 1'b0;
    ce    = 1'b1;

    run("pos_pos", 1000, 7, 142, 6, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("hold.done", done, 0);
    chk("hold.dout", dout, 142);
    chk("hold.rem", rem, 6);

    run("neg_pos", -1000, 7, -142, -6, 1'b0, 1'b0);
    run("pos_neg", 1000, -7, -142, 6, 1'b0, 1'b0);
    run("neg_neg", -1000, -7, 142, -6, 1'b0, 1'b0);

    big = 70'sd1 << 60;
    run("sat_2p60", big, 1, QMAX, 0, 1'b1, 1'b0);
    big = 70'sd1 << 69;
    run("sat_min_m1", big, -1, QMAX, 0, 1'b1, 1'b0);
    big = 70'sd1 << 39;
    run("edge_pos_2p39", big, 1, QMAX, 0, 1'b1, 1'b0);
    run("edge_neg_2p39", big, -1, QMIN, 0, 1'b0, 1'b0);
    run("edge_qmin", -big, 1, QMIN, 0, 1'b0, 1'b0);
    run("edge_qmax", big - 1, 1, QMAX, 0, 1'b0, 1'b0);

    run("divzero_neg", -5, 0, QMIN, -5, 1'b1, 1'b1);
    run("divzero_pos", 12345, 0, QMAX, 12345, 1'b1, 1'b1);

    // Freeze ce for 10 edges mid-calculation.
    do_start(1000, 7);
    wait_done(20, n);
    chk("ce_pause.latency", n, 81);
    chk("ce_pause.dout", dout, 142);

    // Start pulsed while busy must be dropped, not queued.
    do_start(1000, 7);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_mid", busy, 1);
    do_start(77, 3);
    wait_done(-1, n);
    chk("ign_start.latency", n, 60);
    chk("ign_start.dout", dout, 142);
    chk("ign_start.rem", rem, 6);
    @(posedge clk);
    #1;
    chk("ign_start.no_second_busy", busy, 0);
    chk("ign_start.no_second_done", done, 0);

    // A start presented while done is high is accepted.
    do_start(100, 9);
    wait_done(-1, n);
    do_start(-50, 4);
    chk("done_accept.busy", busy, 1);
    chk("done_accept.done", done, 0);
    wait_done(-1, n);
    chk("done_accept.latency", n, 71);
    chk("done_accept.dout", dout, -12);
    chk("done_accept.rem", rem, -2);

    // Reset mid-calculation aborts with no done.
    do_start(1000, 7);
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.dout", dout, 0);
    chk("abort.rem", rem, 0);
    chk("abort.ovf", ovf, 0);
    seen = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("abort.no_done", seen, 0);

    // Round trip: (a*b)/b must return a exactly with zero remainder.
    for (int i = 0; i < 30; i++) begin
      r = {$urandom(), $urandom()};
      a = r[39:0];
      b = $urandom();
      if (b == 0 || b == 31'sh4000_0000) b = 3;
      p = a * b;
      run("round_trip", p, b, a, 0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
